fsm_flow_ctrl: RTL and testbench

//  Parametrised control FSM for the FIFO-based switching datapath. Monitors N FIFOs' empty/error flags,

---
 rtl/fsm_flow_ctrl_if.sv | 29 ++
 rtl/fsm_flow_ctrl.sv | 155 +++++++++++++++
 tb/tb_fsm_flow_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fsm_flow_ctrl_if.sv
// Handshake/status bundle between the FIFO array controller and its environment.
// The master side drives requests and FIFO flags; the slave side (the FSM) returns thresholds and status.
interface fsm_flow_ctrl_if #(
   parameter int NUM_FIFOS = 5,
   parameter int TH_W      = 4
);
   logic                      init;
   logic                      err_clr;
   logic [NUM_FIFOS-1:0]      fifo_empty;
   logic [NUM_FIFOS-1:0]      fifo_error;
   logic [NUM_FIFOS*TH_W-1:0] af_th_in;
   logic [NUM_FIFOS*TH_W-1:0] ae_th_in;
   logic [NUM_FIFOS*TH_W-1:0] af_th_out;
   logic [NUM_FIFOS*TH_W-1:0] ae_th_out;
   logic [NUM_FIFOS-1:0]      error_out;
   logic                      cfg_err_out;
   logic                      idle_out;
   logic                      active_out;

   modport master (
      output init, err_clr, fifo_empty, fifo_error, af_th_in, ae_th_in,
      input  af_th_out, ae_th_out, error_out, cfg_err_out, idle_out, active_out
   );

   modport slave (
      input  init, err_clr, fifo_empty, fifo_error, af_th_in, ae_th_in,
      output af_th_out, ae_th_out, error_out, cfg_err_out, idle_out, active_out
   );
endinterface

// File: rtl/fsm_flow_ctrl.sv
// Control FSM for the FIFO switching datapath: programs per-FIFO af/ae thresholds in INIT,
// tracks idle/active with an idle-hold debounce and keeps sticky per-FIFO errors until cleared.
module fsm_flow_ctrl #(
   parameter int NUM_FIFOS = 5,
   parameter int TH_W      = 4,
   parameter int IDLE_HOLD = 3,
   parameter int DEF_AF    = 12,
   parameter int DEF_AE    = 2
) (
   input  logic           clk,
   input  logic           reset,
   fsm_flow_ctrl_if.slave bus
);
   localparam int VEC_W = NUM_FIFOS * TH_W;
   localparam int CNT_W = $clog2(IDLE_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(IDLE_HOLD - 1);
   localparam logic [TH_W-1:0]  DEF_AF_TH = TH_W'(DEF_AF);
   localparam logic [TH_W-1:0]  DEF_AE_TH = TH_W'(DEF_AE);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   // A threshold set is unusable if any FIFO's almost-empty level reaches its almost-full level.
   function automatic logic th_invalid(input logic [VEC_W-1:0] af, input logic [VEC_W-1:0] ae);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (ae[i*TH_W +: TH_W] >= af[i*TH_W +: TH_W]) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction

   state_t               state_q, state_d;
   logic [VEC_W-1:0]     af_th_q, af_th_d;
   logic [VEC_W-1:0]     ae_th_q, ae_th_d;
   logic [NUM_FIFOS-1:0] error_q, error_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 idle_q, idle_d;
   logic                 active_q, active_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 all_empty_s;
   logic                 any_err_s;

   assign all_empty_s = &bus.fifo_empty;
   assign any_err_s   = |bus.fifo_error;

   // Next-state, threshold, error and debounce-counter logic; status flags follow the next state.
   always_comb begin
      state_d   = state_q;
      af_th_d   = af_th_q;
      ae_th_d   = ae_th_q;
      error_d   = error_q;
      cfg_err_d = cfg_err_q;
      cnt_d     = {CNT_W{1'b0}};
      case (state_q)
         ST_RESET: begin
            state_d = ST_INIT;
         end
         ST_INIT: begin
            af_th_d = bus.af_th_in;
            ae_th_d = bus.ae_th_in;
            if (bus.init) begin
               state_d = ST_INIT;
            end else if (th_invalid(bus.af_th_in, bus.ae_th_in)) begin
               state_d   = ST_ERROR;
               cfg_err_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (any_err_s) begin
               state_d = ST_ERROR;
               error_d = bus.fifo_error;
            end else if (bus.init) begin
               state_d = ST_INIT;
            end else if (!all_empty_s) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (any_err_s) begin
               state_d = ST_ERROR;
               error_d = bus.fifo_error;
            end else if (bus.init) begin
               state_d = ST_INIT;
            end else if (all_empty_s) begin
               // Only a full run of IDLE_HOLD all-empty cycles drops back to IDLE.
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ERROR: begin
            if (bus.err_clr) begin
               state_d   = ST_INIT;
               error_d   = {NUM_FIFOS{1'b0}};
               cfg_err_d = 1'b0;
            end else begin
               error_d = error_q | bus.fifo_error;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
      idle_d   = (state_d == ST_IDLE);
      active_d = (state_d == ST_ACTIVE);
   end

   // State and registered outputs; reset reloads the default thresholds.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RESET;
         af_th_q   <= {NUM_FIFOS{DEF_AF_TH}};
         ae_th_q   <= {NUM_FIFOS{DEF_AE_TH}};
         error_q   <= {NUM_FIFOS{1'b0}};
         cfg_err_q <= 1'b0;
         idle_q    <= 1'b0;
         active_q  <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         af_th_q   <= af_th_d;
         ae_th_q   <= ae_th_d;
         error_q   <= error_d;
         cfg_err_q <= cfg_err_d;
         idle_q    <= idle_d;
         active_q  <= active_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.af_th_out   = af_th_q;
   assign bus.ae_th_out   = ae_th_q;
   assign bus.error_out   = error_q;
   assign bus.cfg_err_out = cfg_err_q;
   assign bus.idle_out    = idle_q;
   assign bus.active_out  = active_q;
endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Directed bench for fsm_flow_ctrl: the driver queues hand-computed expected outputs per edge,
// a monitor pops and compares them one time unit after each rising edge.
module tb_fsm_flow_ctrl;
   localparam logic [19:0] DAF = 20'hCCCCC;
   localparam logic [19:0] DAE = 20'h22222;
   localparam logic [19:0] AAF = 20'hAAAAA;
   localparam logic [19:0] AAE = 20'h33333;
   localparam logic [19:0] BAF = 20'hA9AAA;
   localparam logic [19:0] BAE = 20'h39333;

   typedef struct packed {
      logic        idle;
      logic        active;
      logic        cfg;
      logic [4:0]  err;
      logic [19:0] af;
      logic [19:0] ae;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t exp_q[$];

   fsm_flow_ctrl_if #(.NUM_FIFOS(5), .TH_W(4)) bus ();

   fsm_flow_ctrl #(
      .NUM_FIFOS(5), .TH_W(4), .IDLE_HOLD(3), .DEF_AF(12), .DEF_AE(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [19:0] act, input logic [19:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation for the edge just taken.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("idle_out",    {19'd0, bus.idle_out},    {19'd0, e.idle});
         chk("active_out",  {19'd0, bus.active_out},  {19'd0, e.active});
         chk("cfg_err_out", {19'd0, bus.cfg_err_out}, {19'd0, e.cfg});
         chk("error_out",   {15'd0, bus.error_out},   {15'd0, e.err});
         chk("af_th_out",   bus.af_th_out,            e.af);
         chk("ae_th_out",   bus.ae_th_out,            e.ae);
      end
   end

   task automatic step(input logic rst, input logic ini, input logic clr,
                       input logic [4:0] emp, input logic [4:0] ferr,
                       input logic [19:0] afi, input logic [19:0] aei,
                       input logic x_idle, input logic x_act, input logic x_cfg,
                       input logic [4:0] x_err, input logic [19:0] x_af, input logic [19:0] x_ae);
      exp_t e;
      @(negedge clk);
      reset          = rst;
      bus.init       = ini;
      bus.err_clr    = clr;
      bus.fifo_empty = emp;
      bus.fifo_error = ferr;
      bus.af_th_in   = afi;
      bus.ae_th_in   = aei;
      e = '{idle: x_idle, active: x_act, cfg: x_cfg, err: x_err, af: x_af, ae: x_ae};
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.init = 1'b0;
      bus.err_clr = 1'b0;
      bus.fifo_empty = 5'h1F;
      bus.fifo_error = 5'h00;
      bus.af_th_in = DAF;
      bus.ae_th_in = DAE;
      //   rst   init  clr   empty     error     af_in ae_in  idle  act   cfg   err_out   af   ae
      step(1'b1, 1'b0, 1'b0, 5'h1F,    5'h00,    DAF, DAE,  1'b0, 1'b0, 1'b0, 5'h00,    DAF, DAE);
      step(1'b1, 1'b0, 1'b0, 5'h1F,    5'h00,    DAF, DAE,  1'b0, 1'b0, 1'b0, 5'h00,    DAF, DAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    DAF, DAE,  1'b0, 1'b0, 1'b0, 5'h00,    DAF, DAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    DAF, DAE,  1'b1, 1'b0, 1'b0, 5'h00,    DAF, DAE);
      // Reprogram all FIFOs to af=A, ae=3.
      step(1'b0, 1'b1, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b0, 1'b0, 5'h00,    DAF, DAE);
      step(1'b0, 1'b1, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      // FIFO3 ae=af=9 is invalid; fifo_error is ignored in INIT.
      step(1'b0, 1'b1, 1'b0, 5'h1F,    5'h00,    BAF, BAE,  1'b0, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h1F,    BAF, BAE,  1'b0, 1'b0, 1'b1, 5'h00,    BAF, BAE);
      step(1'b0, 1'b0, 1'b1, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b0, 1'b0, 5'h00,    BAF, BAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      // Idle-hold debounce: two empties, a non-empty resets the count, then three empties.
      step(1'b0, 1'b0, 1'b0, 5'b11011, 5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'b11110, 5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'b01111, 5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      // Sticky accumulating errors; init alone stays in ERROR; clear beats a new error.
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'b00100, AAF, AAE,  1'b0, 1'b0, 1'b0, 5'b00100, AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'b00001, AAF, AAE,  1'b0, 1'b0, 1'b0, 5'b00101, AAF, AAE);
      step(1'b0, 1'b1, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b0, 1'b0, 5'b00101, AAF, AAE);
      step(1'b0, 1'b0, 1'b1, 5'h1F,    5'b10000, AAF, AAE,  1'b0, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      // Error has priority over init in IDLE.
      step(1'b0, 1'b1, 1'b0, 5'h1F,    5'b01000, AAF, AAE,  1'b0, 1'b0, 1'b0, 5'b01000, AAF, AAE);
      step(1'b0, 1'b0, 1'b1, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      // Reset while ACTIVE with cnt=2.
      step(1'b0, 1'b0, 1'b0, 5'h00,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b1, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b0, 1'b0, 5'h00,    DAF, DAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b0, 1'b0, 5'h00,    DAF, DAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'b11110, 5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b0, 1'b1, 1'b0, 5'h00,    AAF, AAE);
      step(1'b0, 1'b0, 1'b0, 5'h1F,    5'h00,    AAF, AAE,  1'b1, 1'b0, 1'b0, 5'h00,    AAF, AAE);
      @(negedge clk);
      chk("scoreboard_drained", 20'(exp_q.size()), 20'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
